// File: rtl/lift_sched_pkg.sv
// Shared call codes, button-index decode and issue-FSM state encoding for the
// hall-call scheduler.
package lift_sched_pkg;

    localparam int N_CALLS = 6;

    localparam logic [2:0] C_NONE = 3'b000;
    localparam logic [2:0] C_1U   = 3'b001;
    localparam logic [2:0] C_2U   = 3'b010;
    localparam logic [2:0] C_3U   = 3'b011;
    localparam logic [2:0] C_2D   = 3'b110;
    localparam logic [2:0] C_3D   = 3'b111;
    localparam logic [2:0] C_4D   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_SETTLE
    } issue_state_t;

    function automatic logic [2:0] idx_to_code(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = C_1U;
            3'd1:    code = C_2U;
            3'd2:    code = C_3U;
            3'd3:    code = C_2D;
            3'd4:    code = C_3D;
            3'd5:    code = C_4D;
            default: code = C_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/lift_rr_arbiter.sv
// Six-way round-robin arbiter. The pointer holds the index where the next
// search begins, i.e. one past the most recent grant.
module lift_rr_arbiter
    import lift_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] req,
    output logic [5:0] grant,
    output logic [2:0] grant_idx,
    output logic       valid
);

    logic [2:0] ptr_reg;
    logic [2:0] ptr_next;
    logic [2:0] cand [N_CALLS];

    // Candidate k is the k-th index visited when searching from ptr_reg.
    generate
        for (genvar gi = 0; gi < N_CALLS; gi++) begin : g_cand
            logic [3:0] sum;
            assign sum      = {1'b0, ptr_reg} + 4'(gi);
            assign cand[gi] = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
        end
    endgenerate

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        ptr_next  = ptr_reg;
        for (int k = 0; k < N_CALLS; k++) begin
            if (!valid && req[cand[k]]) begin
                valid           = 1'b1;
                grant[cand[k]]  = 1'b1;
                grant_idx       = cand[k];
                ptr_next        = (cand[k] == 3'd5) ? 3'd0 : cand[k] + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/lift_call_scheduler.sv
// Hall-call scheduler: dedups button presses, queues them round-robin and
// offers one call at a time to the lift. Optional LIFT_SCHED_WATCHDOG_EN adds
// a sticky stuck-offer watchdog.
module lift_call_scheduler
    import lift_sched_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int WD_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [5:0]                 req,
    input  logic                       done,
    output logic [2:0]                 din,
    output logic                       q_empty,
    output logic [5:0]                 pending,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       stuck
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    issue_state_t   state_reg, state_next;
    logic [5:0]     pending_reg, pending_next;
    logic [5:0]     unqueued_reg, unqueued_next;
    logic [2:0]     fifo_mem [DEPTH];
    logic [PW-1:0]  head_reg, tail_reg;
    logic [CW-1:0]  count_reg, count_next;

    logic [5:0]     arb_grant;
    logic [2:0]     arb_idx;
    logic           push;
    logic           pop;
    logic [2:0]     head_idx;
    logic [5:0]     pop_mask;
    logic [5:0]     set_vec;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    lift_rr_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (unqueued_reg),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (push)
    );

    // The FIFO stores button indices; codes are decoded only when offered.
    assign head_idx = fifo_mem[head_reg];
    assign pop      = (state_reg == ST_OFFER) && done;
    assign pop_mask = pop ? (6'b000001 << head_idx) : 6'b000000;

    // A press landing on the edge that retires the same call starts it afresh.
    assign set_vec       = req & (~pending_reg | pop_mask);
    assign pending_next  = (pending_reg & ~pop_mask) | set_vec;
    assign unqueued_next = (unqueued_reg & ~arb_grant) | set_vec;
    assign count_next    = count_reg + CW'(push) - CW'(pop);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (count_reg != '0) state_next = ST_OFFER;
            end
            ST_OFFER: begin
                if (done) state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_next = (count_reg != '0) ? ST_OFFER : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            pending_reg  <= '0;
            unqueued_reg <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            unqueued_reg <= unqueued_next;
            count_reg    <= count_next;
            if (push) tail_reg <= ptr_inc(tail_reg);
            if (pop)  head_reg <= ptr_inc(head_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[tail_reg] <= arb_idx;
    end

    assign din     = (state_reg == ST_OFFER) ? idx_to_code(head_idx) : C_NONE;
    assign q_empty = (state_reg != ST_OFFER);
    assign pending = pending_reg;
    assign count   = count_reg;

`ifdef LIFT_SCHED_WATCHDOG_EN
    localparam int WW = $clog2(WD_CYCLES + 1);

    logic [WW-1:0] wd_cnt_reg;
    logic          stuck_reg;

    // Counts unanswered offer cycles; saturates so stuck never needs re-arming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_reg <= '0;
            stuck_reg  <= 1'b0;
        end else if ((state_reg == ST_OFFER) && !done) begin
            if (wd_cnt_reg != WW'(WD_CYCLES)) wd_cnt_reg <= wd_cnt_reg + 1'b1;
            if (wd_cnt_reg == WW'(WD_CYCLES - 1)) stuck_reg <= 1'b1;
        end else begin
            wd_cnt_reg <= '0;
        end
    end

    assign stuck = stuck_reg;
`else
    assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed bench for lift_call_scheduler: reset, single call, round-robin
// order, dedup, same-edge requeue, busy lift and watchdog flag.
module tb_lift_call_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] req;
    logic       done;
    logic [2:0] din;
    logic       q_empty;
    logic [5:0] pending;
    logic [3:0] count;
    logic       stuck;

    int checks   = 0;
    int failures = 0;

`ifdef LIFT_SCHED_WATCHDOG_EN
    localparam logic WD_ON = 1'b1;
`else
    localparam logic WD_ON = 1'b0;
`endif

    lift_call_scheduler #(.DEPTH(8), .WD_CYCLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .din     (din),
        .q_empty (q_empty),
        .pending (pending),
        .count   (count),
        .stuck   (stuck)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks += 5;
        if (din !== 3'b000) begin failures++; $display("FAIL reset_din actual=%b required=000", din); end
        if (q_empty !== 1'b1) begin failures++; $display("FAIL reset_q_empty actual=%b required=1", q_empty); end
        if (pending !== 6'b0) begin failures++; $display("FAIL reset_pending actual=%b required=000000", pending); end
        if (count !== 4'd0) begin failures++; $display("FAIL reset_count actual=%0d required=0", count); end
        if (stuck !== 1'b0) begin failures++; $display("FAIL reset_stuck actual=%b required=0", stuck); end
        $display("test_reset: din=%b q_empty=%b count=%0d", din, q_empty, count);
    endtask

    task automatic test_reset_mid_offer();
        done = 1'b0;
        req = 6'b000100; tick();
        req = 6'b000000; tick(); tick();
        checks += 2;
        if (q_empty !== 1'b0) begin failures++; $display("FAIL midoffer_pre_q_empty actual=%b required=0", q_empty); end
        if (din !== 3'b011) begin failures++; $display("FAIL midoffer_pre_din actual=%b required=011", din); end
        rst = 1'b1; #2;
        checks += 4;
        if (pending !== 6'b0) begin failures++; $display("FAIL midoffer_async_pending actual=%b required=000000", pending); end
        if (q_empty !== 1'b1) begin failures++; $display("FAIL midoffer_async_q_empty actual=%b required=1", q_empty); end
        if (din !== 3'b000) begin failures++; $display("FAIL midoffer_async_din actual=%b required=000", din); end
        if (count !== 4'd0) begin failures++; $display("FAIL midoffer_async_count actual=%0d required=0", count); end
        tick(); rst = 1'b0; tick();
        checks += 2;
        if (q_empty !== 1'b1) begin failures++; $display("FAIL midoffer_post_q_empty actual=%b required=1", q_empty); end
        if (count !== 4'd0) begin failures++; $display("FAIL midoffer_post_count actual=%0d required=0", count); end
        $display("test_reset_mid_offer: pending=%b count=%0d", pending, count);
    endtask

    task automatic test_single_call();
        done = 1'b1;
        req = 6'b000100; tick();
        req = 6'b000000;
        checks += 2;
        if (pending !== 6'b000100) begin failures++; $display("FAIL single_e0_pending actual=%b required=000100", pending); end
        if (count !== 4'd0) begin failures++; $display("FAIL single_e0_count actual=%0d required=0", count); end
        tick();
        checks += 2;
        if (count !== 4'd1) begin failures++; $display("FAIL single_e1_count actual=%0d required=1", count); end
        if (q_empty !== 1'b1) begin failures++; $display("FAIL single_e1_q_empty actual=%b required=1", q_empty); end
        tick();
        checks += 2;
        if (din !== 3'b011) begin failures++; $display("FAIL single_e2_din actual=%b required=011", din); end
        if (q_empty !== 1'b0) begin failures++; $display("FAIL single_e2_q_empty actual=%b required=0", q_empty); end
        tick();
        checks += 4;
        if (pending !== 6'b0) begin failures++; $display("FAIL single_e3_pending actual=%b required=000000", pending); end
        if (din !== 3'b000) begin failures++; $display("FAIL single_e3_settle_din actual=%b required=000", din); end
        if (q_empty !== 1'b1) begin failures++; $display("FAIL single_e3_q_empty actual=%b required=1", q_empty); end
        if (count !== 4'd0) begin failures++; $display("FAIL single_e3_count actual=%0d required=0", count); end
        tick();
        $display("test_single_call: call 011 accepted");
    endtask

    // Arbiter pointer sits at index 3 here, so 3D (idx 4) must precede 2U (idx 1).
    task automatic test_rr_rotation();
        done = 1'b0;
        req = 6'b010010; tick();
        req = 6'b000000; tick(); tick();
        checks += 2;
        if (din !== 3'b111) begin failures++; $display("FAIL rr_first_din actual=%b required=111", din); end
        if (count !== 4'd2) begin failures++; $display("FAIL rr_count actual=%0d required=2", count); end
        done = 1'b1; tick();
        checks += 1;
        if (pending !== 6'b000010) begin failures++; $display("FAIL rr_pending_after_pop actual=%b required=000010", pending); end
        tick();
        checks += 1;
        if (din !== 3'b010) begin failures++; $display("FAIL rr_second_din actual=%b required=010", din); end
        tick(); tick();
        checks += 1;
        if (pending !== 6'b0) begin failures++; $display("FAIL rr_end_pending actual=%b required=000000", pending); end
        $display("test_rr_rotation: order 111 then 010");
    endtask

    task automatic test_dedup();
        int max_cnt = 0;
        int accepts = 0;
        done = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req = (i < 3) ? 6'b001000 : 6'b000000;
            tick();
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (din == 3'b110 && done) accepts++;
        end
        checks += 3;
        if (max_cnt != 1) begin failures++; $display("FAIL dedup_peak_count actual=%0d required=1", max_cnt); end
        if (accepts != 1) begin failures++; $display("FAIL dedup_issued actual=%0d required=1", accepts); end
        if (pending !== 6'b0) begin failures++; $display("FAIL dedup_pending actual=%b required=000000", pending); end
        $display("test_dedup: peak=%0d issued=%0d", max_cnt, accepts);
    endtask

    task automatic test_simultaneous();
        rst = 1'b1; tick(); rst = 1'b0; tick();
        done = 1'b0;
        req = 6'b100001; tick();
        req = 6'b000000; tick();
        checks += 1;
        if (count !== 4'd1) begin failures++; $display("FAIL simul_first_push_count actual=%0d required=1", count); end
        tick();
        checks += 2;
        if (din !== 3'b001) begin failures++; $display("FAIL simul_first_din actual=%b required=001", din); end
        if (count !== 4'd2) begin failures++; $display("FAIL simul_count actual=%0d required=2", count); end
        done = 1'b1; tick(); tick();
        checks += 1;
        if (din !== 3'b100) begin failures++; $display("FAIL simul_second_din actual=%b required=100", din); end
        // 4D retires on this edge while 4D and 2U are pressed: 4D is requeued.
        req = 6'b100010; tick();
        req = 6'b000000;
        checks += 2;
        if (pending !== 6'b100010) begin failures++; $display("FAIL requeue_pending actual=%b required=100010", pending); end
        if (count !== 4'd0) begin failures++; $display("FAIL requeue_count actual=%0d required=0", count); end
        tick(); tick();
        checks += 2;
        if (din !== 3'b010) begin failures++; $display("FAIL simul_pair2_first actual=%b required=010", din); end
        if (count !== 4'd2) begin failures++; $display("FAIL simul_pair2_count actual=%0d required=2", count); end
        tick(); tick();
        checks += 1;
        if (din !== 3'b100) begin failures++; $display("FAIL simul_pair2_second actual=%b required=100", din); end
        tick(); tick();
        checks += 2;
        if (pending !== 6'b0) begin failures++; $display("FAIL simul_end_pending actual=%b required=000000", pending); end
        if (q_empty !== 1'b1) begin failures++; $display("FAIL simul_end_q_empty actual=%b required=1", q_empty); end
        $display("test_simultaneous: 001,100 then 010,100");
    endtask

    task automatic test_lift_busy();
        logic exp_stuck;
        done = 1'b0;
        req = 6'b000001; tick();
        req = 6'b000000; tick(); tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_stuck = WD_ON && (i >= 3);
            checks += 3;
            if (din !== 3'b001) begin failures++; $display("FAIL busy_din cycle=%0d actual=%b required=001", i, din); end
            if (count !== 4'd1) begin failures++; $display("FAIL busy_count cycle=%0d actual=%0d required=1", i, count); end
            if (stuck !== exp_stuck) begin failures++; $display("FAIL busy_stuck cycle=%0d actual=%b required=%b", i, stuck, exp_stuck); end
        end
        done = 1'b1; tick();
        checks += 4;
        if (count !== 4'd0) begin failures++; $display("FAIL busy_pop_count actual=%0d required=0", count); end
        if (pending !== 6'b0) begin failures++; $display("FAIL busy_pop_pending actual=%b required=000000", pending); end
        if (q_empty !== 1'b1) begin failures++; $display("FAIL busy_pop_q_empty actual=%b required=1", q_empty); end
        if (stuck !== WD_ON) begin failures++; $display("FAIL busy_stuck_sticky actual=%b required=%b", stuck, WD_ON); end
        tick(); tick();
        $display("test_lift_busy: stuck=%b after accept", stuck);
    endtask

    task automatic test_watchdog_clear();
        rst = 1'b1; tick(); rst = 1'b0; tick();
        checks += 1;
        if (stuck !== 1'b0) begin failures++; $display("FAIL wd_reset_clear actual=%b required=0", stuck); end
        $display("test_watchdog_clear: stuck=%b", stuck);
    endtask

    initial begin
        rst  = 1'b1;
        req  = 6'b0;
        done = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_reset_mid_offer();
        test_single_call();
        test_rr_rotation();
        test_dedup();
        test_simultaneous();
        test_lift_busy();
        test_watchdog_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
